mipi_tx_packet_builder: RTL and testbench
=========================================

Name: mipi_tx_packet_builder

Overview:
- Transmit-side counterpart of the DSI receive path (serdes, byte/lane aligners, packet slicer).
- Takes one DSI packet request (short or long) plus a 32-bit payload stream and emits a 4-lane HS byte stream for the output serializer.
- Each request produces exactly one HS burst: SoT sync, packet header with ECC, payload, CRC-16, then per-lane trail bytes.
- Output byte n of a burst goes to lane n mod 4, matching the receiver's lane mapping.

Parameters:
TRAIL_CYCLES, 2, number of full all-lane trail cycles after the last data word (1..15)
GAP_CYCLES, 4, minimum cycles with dout_valid low between bursts (LP gap; 1..255)

Ports:
clk  input  1  byte clock; all logic is in this domain
rst  input  1  synchronous reset, active-high
pkt_valid  input  1  packet request valid
pkt_ready  output  1  request accepted when pkt_valid && pkt_ready
pkt_long  input  1  1 = long packet, 0 = short packet
pkt_di  input  8  data identifier (VC[7:6], DT[5:0])
pkt_wc  input  16  long: word count in bytes; short: {data1, data0}
din  input  32  payload word; byte k in din[k*8+7 -: 8]
din_valid  input  1  payload word available
din_ready  output  1  payload word consumed this cycle
dout  output  32  lane bytes; lane i in dout[i*8+7 -: 8]
dout_valid  output  1  HS burst active on all 4 lanes
underrun  output  1  one-cycle pulse: payload word needed but din_valid low

Behaviour:
- Reset: pkt_ready=0 in the reset cycle, then 1; din_ready=0, dout=0, dout_valid=0, underrun=0. GAP counter is cleared, so a request may be accepted immediately after reset.
- Reset asserted mid-burst aborts it. All outputs return to reset values on the next edge, and there is no trail.
- States: IDLE, SOT, HDR, PAY, TRAIL, GAP. Outputs are registered.
- IDLE:
  - pkt_ready=1.
  - On accept, latch di, wc and long, seed CRC to 0xFFFF, and go to SOT.
  - pkt_ready=0 in every other state.
- SOT (1 cycle): dout=0xB8B8B8B8, dout_valid=1, so dout_valid rises on the first edge after accept.
- HDR (1 cycle):
  - Lanes 0..3 carry DI, WC[7:0], WC[15:8], ECC.
  - ECC is the DSI 6-bit Hamming code over the 24 header bits, with ECC[7:6]=0.
  - Short packet: next state is TRAIL. Long packet: next state is PAY.
- PAY:
  - Stream = WC payload bytes followed by CRC low byte, then CRC high byte; N = WC+2 bytes over ceil(N/4) cycles.
  - din_ready=1 only in PAY cycles that need at least one payload byte.
  - Bytes beyond WC in the final input word are ignored, and CRC bytes pack into the remaining slots of that word.
  - CRC: CCITT x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF, no final XOR, over the payload bytes in order. Implement as a 4-byte-per-cycle combinational update with a partial-word byte count.
  - WC=0: a single PAY word carrying 0xFF, 0xFF on lanes 0 and 1; din_ready stays 0.
  - Lanes with no byte in the final word carry that lane's trail byte.
- Underrun: a PAY cycle needs a word but din_valid=0.
  - underrun pulses and 0x00 is sent in the needed byte slots; the CRC includes the substituted zeros.
  - The burst continues with the same timing; HS cannot stall.
- Trail byte per lane: {8{~b}}, where b is bit 7 of the last data byte sent on that lane. The byte is serialized LSB first, so bit 7 is the last bit on the wire.
- TRAIL: TRAIL_CYCLES cycles of per-lane trail bytes with dout_valid=1, then GAP.
- GAP: dout_valid=0 and dout=0 for GAP_CYCLES cycles, then IDLE.
- Latency: total burst cycles with dout_valid=1 = 2 + (long ? ceil((WC+2)/4) : 0) + TRAIL_CYCLES.
- WC=0xFFFF: the cycle counter must hold at least 17 bits; there is no overflow.

Test Plan:
1. Short, DI=0x00, data=0x0000, TRAIL_CYCLES=2 -> dout 0xB8B8B8B8, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF; then dout_valid=0 for 4 cycles; pkt_ready reasserts on the 5th cycle.
2. Long, DI=0x39, WC=0 -> the HDR ECC matches the model; the PAY word has lanes 0,1 = 0xFF and lanes 2,3 = trail of the WC high byte and ECC; lane 0,1 trail = 0x00; din_ready never high.
3. Long, WC=6, bytes 0x01..0x06 in two input words -> the PAY words are {04,03,02,01} and {crcH,crcL,06,05} (lanes 3..0), with the CRC equal to the model; din_ready high exactly 2 cycles; bytes 2,3 of the second input word are ignored.
4. Long, WC=8, with din_valid dropped in the second PAY cycle -> a single underrun pulse; lanes carry 0x00 in that word; the CRC is computed over the zeros; burst length is unchanged at 2+3+2 cycles.
5. rst asserted in the second PAY cycle of a WC=16 burst -> the next edge has dout_valid=0, dout=0 and din_ready=0; pkt_ready=1 the cycle after rst falls; the next request produces a clean burst.
6. pkt_valid held high with two queued requests -> pkt_ready=0 from SOT through GAP; the second SOT appears exactly GAP_CYCLES+1 cycles after the first burst's last dout_valid.

Source files
------------

// File: rtl/mipi_tx_packet_builder.sv
// mipi_tx_packet_builder: turns one DSI short/long packet request plus a 32-bit payload stream into a 4-lane HS byte burst.
module mipi_tx_packet_builder #(
  parameter int TRAIL_CYCLES = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [7:0]  pkt_di,
  input  logic [15:0] pkt_wc,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        underrun
);
  typedef enum logic [2:0] {IDLE, SOT, HDR, PAY, TRAIL, GAP} state_e;
  state_e state_q;
  logic [7:0] di_q, tcnt_q, ecc;
  logic [15:0] wc_q, crc_q, crc_d;
  logic long_q;
  logic [16:0] pos_q, wc_x;
  logic [3:0] last_q, last_d;
  logic [31:0] dat, pay_d, trail_d;
  logic [3:0][16:0] idx;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 16'h8408 : 16'h0000);
    return r;
  endfunction
  function automatic logic [7:0] ecc_f(input logic [23:0] d);
    return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
  assign ecc = ecc_f({wc_q, di_q});
  assign wc_x = {1'b0, wc_q};
  // A missing payload word is replaced by zeros, which also feed the CRC.
  assign dat = din_valid ? din : 32'h0;
  // Build the next PAY word: payload bytes, then CRC low/high, then per-lane trail fill.
  always_comb begin
    crc_d = crc_q;
    idx = '0;
    pay_d = '0;
    trail_d = '0;
    last_d = last_q;
    for (int k = 0; k < 4; k++) begin
      idx[k] = pos_q + 17'(k);
      trail_d[8*k +: 8] = {8{~last_q[k]}};
      if (idx[k] < wc_x) crc_d = crc_byte(crc_d, dat[8*k +: 8]);
    end
    for (int k = 0; k < 4; k++) begin
      pay_d[8*k +: 8] = idx[k] < wc_x ? dat[8*k +: 8] :
                        idx[k] == wc_x ? crc_d[7:0] :
                        idx[k] == wc_x + 17'd1 ? crc_d[15:8] : trail_d[8*k +: 8];
      last_d[k] = idx[k] < wc_x + 17'd2 ? pay_d[8*k+7] : last_q[k];
    end
  end
  // din_ready is raised the cycle before the word it feeds appears on dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_ready <= 1'b0;
      din_ready <= 1'b0;
      dout <= '0;
      dout_valid <= 1'b0;
      underrun <= 1'b0;
      di_q <= '0;
      wc_q <= '0;
      long_q <= 1'b0;
      crc_q <= 16'hFFFF;
      pos_q <= '0;
      tcnt_q <= '0;
      last_q <= '0;
    end else begin
      underrun <= 1'b0;
      case (state_q)
        IDLE:
          if (pkt_valid && pkt_ready) begin
            state_q <= SOT;
            pkt_ready <= 1'b0;
            di_q <= pkt_di;
            wc_q <= pkt_wc;
            long_q <= pkt_long;
            crc_q <= 16'hFFFF;
            pos_q <= '0;
            dout <= 32'hB8B8B8B8;
            dout_valid <= 1'b1;
          end else pkt_ready <= 1'b1;
        SOT: begin
          state_q <= HDR;
          dout <= {ecc, wc_q[15:8], wc_q[7:0], di_q};
          last_q <= {ecc[7], wc_q[15], wc_q[7], di_q[7]};
          din_ready <= long_q && wc_q != 16'h0;
        end
        HDR, PAY:
          if (state_q == HDR ? long_q : pos_q < wc_x + 17'd2) begin
            state_q <= PAY;
            dout <= pay_d;
            last_q <= last_d;
            crc_q <= crc_d;
            pos_q <= pos_q + 17'd4;
            din_ready <= pos_q + 17'd4 < wc_x;
            underrun <= din_ready && !din_valid;
          end else begin
            state_q <= TRAIL;
            dout <= trail_d;
            tcnt_q <= 8'(TRAIL_CYCLES - 1);
          end
        TRAIL:
          if (tcnt_q == 8'd0) begin
            state_q <= GAP;
            dout <= '0;
            dout_valid <= 1'b0;
            tcnt_q <= 8'(GAP_CYCLES - 1);
          end else tcnt_q <= tcnt_q - 8'd1;
        GAP:
          if (tcnt_q == 8'd0) begin
            state_q <= IDLE;
            pkt_ready <= 1'b1;
          end else tcnt_q <= tcnt_q - 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mipi_tx_packet_builder.sv
// tb_mipi_tx_packet_builder: directed checks of burst framing, ECC/CRC, trail, underrun, abort and back-to-back requests.
module tb_mipi_tx_packet_builder;
  logic clk = 1'b0, rst = 1'b1;
  logic pkt_valid = 1'b0, pkt_long = 1'b0, din_valid = 1'b0;
  logic [7:0] pkt_di = '0;
  logic [15:0] pkt_wc = '0;
  logic [31:0] din = '0;
  logic pkt_ready, din_ready, dout_valid, underrun;
  logic [31:0] dout;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mipi_tx_packet_builder #(.TRAIL_CYCLES(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_long(pkt_long),
    .pkt_di(pkt_di), .pkt_wc(pkt_wc), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .underrun(underrun));
  function automatic logic [7:0] ecc_m(input logic [23:0] d);
    logic [7:0] p;
    p = '0;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = b ^ c[7:0];
    x = x ^ (x << 4);
    return {x, c[15:8]} ^ {8'h00, x >> 4} ^ ({8'h00, x} << 3);
  endfunction
  function automatic logic [7:0] tr(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [31:0] d, input logic dv, input logic dr, input logic ur);
    chk({tag, "_dout"}, dout, d);
    chk({tag, "_dv"}, {31'd0, dout_valid}, {31'd0, dv});
    chk({tag, "_dinrdy"}, {31'd0, din_ready}, {31'd0, dr});
    chk({tag, "_underrun"}, {31'd0, underrun}, {31'd0, ur});
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send(input logic lng, input logic [7:0] di, input logic [15:0] wc);
    pkt_valid = 1'b1;
    pkt_long = lng;
    pkt_di = di;
    pkt_wc = wc;
    tick;
    pkt_valid = 1'b0;
  endtask
  task automatic wait_idle;
    int n;
    n = 0;
    while (!pkt_ready && n < 40) begin
      tick;
      n++;
    end
    chk("idle_wait", {31'd0, pkt_ready}, 32'd1);
  endtask
  initial begin
    logic [7:0] e;
    logic [15:0] c;
    int gap;
    tick;
    tick;
    outs("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", {31'd0, pkt_ready}, 32'd1);
    // short all-zero packet: framing, trail and gap timing
    send(1'b0, 8'h00, 16'h0000);
    outs("t1_sot", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick; outs("t1_hdr", 32'h00000000, 1'b1, 1'b0, 1'b0);
    tick; outs("t1_tr0", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tick; outs("t1_tr1", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      outs("t1_gap", 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t1_gap_ready", {31'd0, pkt_ready}, 32'd0);
    end
    tick;
    chk("t1_ready_back", {31'd0, pkt_ready}, 32'd1);
    chk("t1_idle_dv", {31'd0, dout_valid}, 32'd0);
    // long packet, WC=0
    e = ecc_m(24'h000039);
    send(1'b1, 8'h39, 16'd0);
    outs("t2_sot", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick; outs("t2_hdr", {e, 8'h00, 8'h00, 8'h39}, 1'b1, 1'b0, 1'b0);
    tick; outs("t2_pay", {tr(e), tr(8'h00), 8'hFF, 8'hFF}, 1'b1, 1'b0, 1'b0);
    tick; outs("t2_tr0", {tr(e), tr(8'h00), 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0);
    tick; outs("t2_tr1", {tr(e), tr(8'h00), 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0);
    tick; outs("t2_gap", 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle;
    // long packet, WC=6, partial final word
    c = 16'hFFFF;
    for (int i = 1; i <= 6; i++) c = crc_upd(c, 8'(i));
    e = ecc_m({16'd6, 8'h29});
    send(1'b1, 8'h29, 16'd6);
    outs("t3_sot", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick; outs("t3_hdr", {e, 8'h00, 8'h06, 8'h29}, 1'b1, 1'b1, 1'b0);
    din = 32'h04030201; din_valid = 1'b1;
    tick; outs("t3_pay0", 32'h04030201, 1'b1, 1'b1, 1'b0);
    din = 32'hEEDD0605;
    tick; outs("t3_pay1", {c[15:8], c[7:0], 8'h06, 8'h05}, 1'b1, 1'b0, 1'b0);
    din_valid = 1'b0;
    tick; outs("t3_tr0", {tr(c[15:8]), tr(c[7:0]), 8'hFF, 8'hFF}, 1'b1, 1'b0, 1'b0);
    tick; outs("t3_tr1", {tr(c[15:8]), tr(c[7:0]), 8'hFF, 8'hFF}, 1'b1, 1'b0, 1'b0);
    tick; outs("t3_gap", 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle;
    // long packet, WC=8, second word missing
    c = 16'hFFFF;
    c = crc_upd(c, 8'h11); c = crc_upd(c, 8'h22); c = crc_upd(c, 8'h33); c = crc_upd(c, 8'h44);
    for (int i = 0; i < 4; i++) c = crc_upd(c, 8'h00);
    e = ecc_m({16'd8, 8'h29});
    send(1'b1, 8'h29, 16'd8);
    outs("t4_sot", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick; outs("t4_hdr", {e, 8'h00, 8'h08, 8'h29}, 1'b1, 1'b1, 1'b0);
    din = 32'h44332211; din_valid = 1'b1;
    tick; outs("t4_pay0", 32'h44332211, 1'b1, 1'b1, 1'b0);
    din = 32'h99999999; din_valid = 1'b0;
    tick; outs("t4_pay1", 32'h00000000, 1'b1, 1'b0, 1'b1);
    tick; outs("t4_pay2", {8'hFF, 8'hFF, c[15:8], c[7:0]}, 1'b1, 1'b0, 1'b0);
    tick; outs("t4_tr0", {8'hFF, 8'hFF, tr(c[15:8]), tr(c[7:0])}, 1'b1, 1'b0, 1'b0);
    tick; outs("t4_tr1", {8'hFF, 8'hFF, tr(c[15:8]), tr(c[7:0])}, 1'b1, 1'b0, 1'b0);
    tick; outs("t4_end", 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle;
    // reset in the middle of a WC=16 burst, then a clean short packet
    send(1'b1, 8'h39, 16'd16);
    outs("t5_sot", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick;
    din = 32'h01020304; din_valid = 1'b1;
    tick; outs("t5_pay0", 32'h01020304, 1'b1, 1'b1, 1'b0);
    tick; outs("t5_pay1", 32'h01020304, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick; outs("t5_abort", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t5_abort_ready", {31'd0, pkt_ready}, 32'd0);
    rst = 1'b0; din_valid = 1'b0;
    tick; chk("t5_ready_back", {31'd0, pkt_ready}, 32'd1);
    outs("t5_idle", 32'h0, 1'b0, 1'b0, 1'b0);
    e = ecc_m({16'h9C81, 8'h15});
    send(1'b0, 8'h15, 16'h9C81);
    outs("t5_sot2", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    tick; outs("t5_hdr", {e, 8'h9C, 8'h81, 8'h15}, 1'b1, 1'b0, 1'b0);
    tick; outs("t5_tr0", {tr(e), 8'h00, 8'h00, 8'hFF}, 1'b1, 1'b0, 1'b0);
    tick; outs("t5_tr1", {tr(e), 8'h00, 8'h00, 8'hFF}, 1'b1, 1'b0, 1'b0);
    tick; outs("t5_gap", 32'h0, 1'b0, 1'b0, 1'b0);
    wait_idle;
    // request held valid: second burst only after the full gap
    pkt_valid = 1'b1; pkt_long = 1'b0; pkt_di = 8'h01; pkt_wc = 16'h0000;
    tick; outs("t6_sot1", 32'hB8B8B8B8, 1'b1, 1'b0, 1'b0);
    chk("t6_sot_ready", {31'd0, pkt_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_busy_ready", {31'd0, pkt_ready}, 32'd0);
      chk("t6_busy_dv", {31'd0, dout_valid}, 32'd1);
    end
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (dout_valid) break;
      chk("t6_gap_ready", {31'd0, pkt_ready}, {31'd0, gap == 4});
      gap++;
    end
    chk("t6_gap_len", gap, 32'd5);
    chk("t6_sot2", dout, 32'hB8B8B8B8);
    pkt_valid = 1'b0;
    wait_idle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
